// File: rtl/pwm_pkg.sv
// Shared types and default constants for the PWM duty sequencer slice.
// The arbiter and the ramp controller both take their defaults from here.
package pwm_pkg;

   localparam int DUTY_W       = 4;
   localparam int MAX_DUTY     = 10;
   localparam int INIT_DUTY    = 5;
   localparam int RAMP_PERIODS = 2;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_req_arbiter.sv
// Combinational request arbiter: host load beats the buttons, and every
// candidate target is clamped to [0, MAX_DUTY] before it reaches the register.
module pwm_req_arbiter #(
   parameter int DUTY_W   = pwm_pkg::DUTY_W,
   parameter int MAX_DUTY = pwm_pkg::MAX_DUTY
) (
   input  logic [DUTY_W-1:0] i_target,
   input  logic              i_load_req,
   input  logic              i_load_ack,
   input  logic [DUTY_W-1:0] i_load_val,
   input  logic              i_inc,
   input  logic              i_dec,
   output logic [DUTY_W-1:0] o_target_next,
   output logic              o_load_accept
);
   import pwm_pkg::*;

   localparam logic [DUTY_W-1:0] MAX_V = DUTY_W'(MAX_DUTY);
   localparam logic [DUTY_W-1:0] ONE_V = DUTY_W'(1);

   function automatic logic [DUTY_W-1:0] clamp_max(input logic [DUTY_W-1:0] v);
      return (v > MAX_V) ? MAX_V : v;
   endfunction

   function automatic logic [DUTY_W-1:0] sat_inc(input logic [DUTY_W-1:0] v);
      return (v >= MAX_V) ? MAX_V : v + ONE_V;
   endfunction

   function automatic logic [DUTY_W-1:0] sat_dec(input logic [DUTY_W-1:0] v);
      return (v == '0) ? '0 : v - ONE_V;
   endfunction

   logic load_win;
   logic inc_only;
   logic dec_only;

   // An ack in the previous cycle blocks a held request, so the host sees
   // at most one acceptance every other cycle.
   always_comb begin
      load_win = i_load_req && !i_load_ack;
      inc_only = i_inc && !i_dec;
      dec_only = i_dec && !i_inc;
   end

   always_comb begin
      o_load_accept = load_win;
      o_target_next = i_target;
      if (load_win) begin
         o_target_next = clamp_max(i_load_val);
      end else if (inc_only) begin
         o_target_next = sat_inc(i_target);
      end else if (dec_only) begin
         o_target_next = sat_dec(i_target);
      end
   end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer: holds a target duty and walks the applied duty one
// step toward it every RAMP_PERIODS PWM periods, only on period boundaries.
module pwm_duty_sequencer #(
   parameter int DUTY_W       = pwm_pkg::DUTY_W,
   parameter int MAX_DUTY     = pwm_pkg::MAX_DUTY,
   parameter int INIT_DUTY    = pwm_pkg::INIT_DUTY,
   parameter int RAMP_PERIODS = pwm_pkg::RAMP_PERIODS
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_period_end,
   input  logic              i_inc,
   input  logic              i_dec,
   input  logic              i_load_req,
   input  logic [DUTY_W-1:0] i_load_val,
   output logic              o_load_ack,
   output logic [DUTY_W-1:0] o_duty,
   output logic [DUTY_W-1:0] o_target,
   output logic              o_busy,
   output logic              o_duty_upd
);
   import pwm_pkg::*;

   localparam int CNT_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_PERIODS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [DUTY_W-1:0] INIT_V   = DUTY_W'(INIT_DUTY);
   localparam logic [DUTY_W-1:0] ONE_V    = DUTY_W'(1);

   function automatic state_t dir_of(input logic [DUTY_W-1:0] duty,
                                     input logic [DUTY_W-1:0] target);
      if (duty < target) begin
         return ST_UP;
      end else if (duty > target) begin
         return ST_DOWN;
      end
      return ST_IDLE;
   endfunction

   state_t            state_q,  state_d;
   logic [DUTY_W-1:0] duty_q,   duty_d;
   logic [DUTY_W-1:0] target_q, target_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              ack_q,    ack_d;
   logic              upd_q,    upd_d;

   logic [DUTY_W-1:0] arb_target;
   logic              arb_accept;
   logic              ramping;
   logic              step;

   pwm_req_arbiter #(
      .DUTY_W   (DUTY_W),
      .MAX_DUTY (MAX_DUTY)
   ) u_arb (
      .i_target      (target_q),
      .i_load_req    (i_load_req),
      .i_load_ack    (ack_q),
      .i_load_val    (i_load_val),
      .i_inc         (i_inc),
      .i_dec         (i_dec),
      .o_target_next (arb_target),
      .o_load_accept (arb_accept)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         duty_q   <= INIT_V;
         target_q <= INIT_V;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         upd_q    <= upd_d;
      end
   end

   // The step direction comes from the registered state; the new state is
   // recomputed from the post-edge duty/target so it never goes stale.
   always_comb begin
      target_d = arb_target;
      ack_d    = arb_accept;
      duty_d   = duty_q;
      cnt_d    = cnt_q;
      if (!ramping) begin
         cnt_d = '0;
      end else if (i_period_end) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
      end
      if (step) begin
         duty_d = (state_q == ST_UP) ? duty_q + ONE_V : duty_q - ONE_V;
      end
      upd_d   = step;
      state_d = dir_of(duty_d, target_d);
   end

   always_comb begin
      ramping    = (state_q != ST_IDLE);
      step       = ramping && i_period_end && (cnt_q == CNT_LAST);
      o_busy     = ramping;
      o_duty     = duty_q;
      o_target   = target_q;
      o_load_ack = ack_q;
      o_duty_upd = upd_q;
   end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scenario bench for pwm_duty_sequencer: expected duty steps are queued as
// stimulus is applied and consumed whenever the DUT pulses o_duty_upd.
module tb_pwm_duty_sequencer;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       period_end = 1'b0;
   logic       inc        = 1'b0;
   logic       dec        = 1'b0;
   logic       load_req   = 1'b0;
   logic [3:0] load_val   = 4'd0;
   logic       o_load_ack;
   logic [3:0] o_duty;
   logic [3:0] o_target;
   logic       o_busy;
   logic       o_duty_upd;

   int         errors   = 0;
   int         checks   = 0;
   logic [3:0] sb[$];
   logic [3:0] mon_exp;
   bit         pe_en    = 1'b0;
   int         pe_cnt   = 0;
   int         pe_total = 0;

   pwm_duty_sequencer dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_period_end (period_end),
      .i_inc        (inc),
      .i_dec        (dec),
      .i_load_req   (load_req),
      .i_load_val   (load_val),
      .o_load_ack   (o_load_ack),
      .o_duty       (o_duty),
      .o_target     (o_target),
      .o_busy       (o_busy),
      .o_duty_upd   (o_duty_upd)
   );

   initial forever #5 clk = ~clk;

   // PWM period strobe: one pulse every 10 cycles while enabled, driven on negedge.
   initial forever begin
      @(negedge clk);
      if (pe_en) begin
         if (pe_cnt == 9) begin
            period_end = 1'b1;
            pe_cnt     = 0;
            pe_total++;
         end else begin
            period_end = 1'b0;
            pe_cnt++;
         end
      end else begin
         period_end = 1'b0;
         pe_cnt     = 0;
      end
   end

   // Every update pulse must match the next queued duty value.
   initial forever begin
      @(negedge clk);
      if (o_duty_upd) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL upd_unexpected: o_duty=%0d, no step expected", o_duty);
         end else begin
            mon_exp = sb.pop_front();
            if (o_duty !== mon_exp) begin
               errors++;
               $display("FAIL upd_duty: o_duty=%0d expected %0d", o_duty, mon_exp);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      pe_en = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic host_load(input logic [3:0] v, input bit with_dec);
      load_req = 1'b1;
      load_val = v;
      dec      = with_dec;
      tick();
      load_req = 1'b0;
      dec      = 1'b0;
   endtask

   task automatic pulse(input bit p_inc, input bit p_dec);
      inc = p_inc;
      dec = p_dec;
      tick();
      inc = 1'b0;
      dec = 1'b0;
      tick();
   endtask

   task automatic wait_pe(input int n);
      int goal;
      int budget;
      goal   = pe_total + n;
      budget = 0;
      while (pe_total < goal && budget < 2000) begin
         tick();
         budget++;
      end
      if (pe_total < goal) begin
         checks++;
         errors++;
         $display("FAIL wait_pe_timeout: seen %0d period ends, needed %0d", pe_total, goal);
      end
   endtask

   task automatic wait_duty(input logic [3:0] v, input int budget);
      int n;
      n = 0;
      while (o_duty !== v && n < budget) begin
         tick();
         n++;
      end
      if (o_duty !== v) begin
         checks++;
         errors++;
         $display("FAIL wait_duty_timeout: o_duty=%0d never reached %0d", o_duty, v);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(2);
      checks++; if (o_duty !== 4'd5)   begin errors++; $display("FAIL rst_duty: got %0d want 5", o_duty); end
      checks++; if (o_target !== 4'd5) begin errors++; $display("FAIL rst_target: got %0d want 5", o_target); end
      checks++; if (o_busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %0b want 0", o_busy); end
      checks++; if (o_load_ack !== 1'b0 || o_duty_upd !== 1'b0) begin
         errors++; $display("FAIL rst_pulses: ack=%0b upd=%0b want 0 0", o_load_ack, o_duty_upd);
      end
      rst_n = 1'b1;
      pe_en = 1'b1;
      tick(100);
      checks++; if (o_duty !== 4'd5 || o_busy !== 1'b0) begin
         errors++; $display("FAIL idle_hold: duty=%0d busy=%0b want 5 0", o_duty, o_busy);
      end
      pe_en = 1'b0;
      tick(2);
   endtask

   task automatic test_inc_ramp();
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      checks++; if (o_target !== 4'd7 || o_busy !== 1'b1) begin
         errors++; $display("FAIL inc_target: target=%0d busy=%0b want 7 1", o_target, o_busy);
      end
      sb.push_back(4'd6);
      sb.push_back(4'd7);
      pe_en = 1'b1;
      wait_pe(1);
      checks++; if (o_duty !== 4'd5) begin errors++; $display("FAIL inc_pe1: duty=%0d want 5", o_duty); end
      wait_pe(1);
      checks++; if (o_duty !== 4'd6) begin errors++; $display("FAIL inc_pe2: duty=%0d want 6", o_duty); end
      wait_pe(2);
      checks++; if (o_duty !== 4'd7) begin errors++; $display("FAIL inc_pe4: duty=%0d want 7", o_duty); end
      tick(2);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL inc_done_busy: busy=%0b want 0", o_busy); end
      pe_en = 1'b0;
      tick();
   endtask

   task automatic test_load_clamp();
      reset_dut();
      host_load(4'd13, 1'b1);
      checks++; if (o_load_ack !== 1'b1) begin errors++; $display("FAIL load_ack_hi: ack=%0b want 1", o_load_ack); end
      checks++; if (o_target !== 4'd10)  begin errors++; $display("FAIL load_clamp: target=%0d want 10", o_target); end
      tick();
      checks++; if (o_load_ack !== 1'b0) begin errors++; $display("FAIL load_ack_lo: ack=%0b want 0", o_load_ack); end
      checks++; if (o_target !== 4'd10)  begin errors++; $display("FAIL load_dec_drop: target=%0d want 10", o_target); end
      for (int v = 6; v <= 10; v++) sb.push_back(4'(v));
      pe_en = 1'b1;
      wait_pe(10);
      checks++; if (o_duty !== 4'd10) begin errors++; $display("FAIL load_ramp: duty=%0d want 10", o_duty); end
      tick(2);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL load_done_busy: busy=%0b want 0", o_busy); end
      pe_en = 1'b0;
      pulse(1'b1, 1'b0);
      checks++; if (o_target !== 4'd10) begin errors++; $display("FAIL inc_sat_max: target=%0d want 10", o_target); end
   endtask

   task automatic test_held_request();
      bit exp_ack[4];
      exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0};
      load_req = 1'b1;
      load_val = 4'd10;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (o_load_ack !== exp_ack[i]) begin
            errors++; $display("FAIL held_ack%0d: ack=%0b want %0b", i, o_load_ack, exp_ack[i]);
         end
      end
      load_req = 1'b0;
      tick();
      checks++; if (o_load_ack !== 1'b0 || o_busy !== 1'b0) begin
         errors++; $display("FAIL held_release: ack=%0b busy=%0b want 0 0", o_load_ack, o_busy);
      end
   endtask

   task automatic test_floor();
      host_load(4'd0, 1'b0);
      checks++; if (o_target !== 4'd0) begin errors++; $display("FAIL floor_load: target=%0d want 0", o_target); end
      repeat (3) pulse(1'b0, 1'b1);
      checks++; if (o_target !== 4'd0) begin errors++; $display("FAIL floor_dec_sat: target=%0d want 0", o_target); end
      pulse(1'b1, 1'b1);
      checks++; if (o_target !== 4'd0) begin errors++; $display("FAIL floor_incdec: target=%0d want 0", o_target); end
      for (int v = 9; v >= 0; v--) sb.push_back(4'(v));
      pe_en = 1'b1;
      wait_duty(4'd0, 600);
      tick(30);
      checks++; if (o_duty !== 4'd0 || o_busy !== 1'b0) begin
         errors++; $display("FAIL floor_ramp: duty=%0d busy=%0b want 0 0", o_duty, o_busy);
      end
      pe_en = 1'b0;
      host_load(4'd3, 1'b0);
      tick();
      pulse(1'b1, 1'b1);
      checks++; if (o_target !== 4'd3) begin errors++; $display("FAIL incdec_nochange: target=%0d want 3", o_target); end
   endtask

   task automatic test_reversal();
      reset_dut();
      host_load(4'd10, 1'b0);
      tick();
      sb.push_back(4'd6);
      sb.push_back(4'd7);
      pe_en = 1'b1;
      wait_duty(4'd7, 200);
      host_load(4'd4, 1'b0);
      checks++; if (o_target !== 4'd4 || o_busy !== 1'b1 || o_duty !== 4'd7) begin
         errors++; $display("FAIL rev_load: target=%0d busy=%0b duty=%0d want 4 1 7", o_target, o_busy, o_duty);
      end
      sb.push_back(4'd6);
      sb.push_back(4'd5);
      sb.push_back(4'd4);
      wait_duty(4'd4, 300);
      tick(30);
      checks++; if (o_duty !== 4'd4 || o_target !== 4'd4 || o_busy !== 1'b0) begin
         errors++; $display("FAIL rev_final: duty=%0d target=%0d busy=%0b want 4 4 0", o_duty, o_target, o_busy);
      end
      pe_en = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      reset_dut();
      host_load(4'd9, 1'b0);
      sb.push_back(4'd6);
      pe_en = 1'b1;
      wait_pe(2);
      checks++; if (o_duty !== 4'd6) begin errors++; $display("FAIL ar_pre: duty=%0d want 6", o_duty); end
      wait_pe(1);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (o_duty !== 4'd5 || o_target !== 4'd5 || o_busy !== 1'b0) begin
         errors++; $display("FAIL ar_immediate: duty=%0d target=%0d busy=%0b want 5 5 0", o_duty, o_target, o_busy);
      end
      pe_en = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      checks++; if (o_target !== 4'd5 || o_busy !== 1'b0) begin
         errors++; $display("FAIL ar_release: target=%0d busy=%0b want 5 0", o_target, o_busy);
      end
      host_load(4'd6, 1'b0);
      sb.push_back(4'd6);
      pe_en = 1'b1;
      wait_pe(1);
      checks++; if (o_duty !== 4'd5) begin errors++; $display("FAIL ar_cnt_clear: duty=%0d want 5", o_duty); end
      wait_pe(1);
      checks++; if (o_duty !== 4'd6) begin errors++; $display("FAIL ar_step: duty=%0d want 6", o_duty); end
      tick(3);
      pe_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_inc_ramp();
      test_load_clamp();
      test_held_request();
      test_floor();
      test_reversal();
      test_async_reset();
      tick(3);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_drain: %0d expected steps never seen", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
